// File: rtl/pt_tx_frame_pkg.sv
// Shared definitions for the PT2262-style frame encoder.
//   - trit code constants (2 bits each, MSB pair of a word is sent first)
//   - waveform timing constants in ticks
//   - FSM state type
//   - trit_high(): envelope level of a data trit at a given tick
package pt_pkg;

  localparam logic [1:0] PT_ZERO    = 2'b00;
  localparam logic [1:0] PT_ONE     = 2'b01;
  localparam logic [1:0] PT_FLOAT   = 2'b10;
  localparam logic [1:0] PT_INVALID = 2'b11;

  // Tick counts are kept 8 bits wide so a whole sync bit (128 ticks) fits.
  localparam logic [7:0] T_SHORT    = 8'd4;
  localparam logic [7:0] T_LONG     = 8'd12;
  localparam logic [7:0] TRIT_TICKS = 8'd32;
  localparam logic [7:0] SYNC_TICKS = 8'd128;

  typedef enum logic [1:0] {IDLE, DATA, SYNC} pt_state_t;

  // A trit is two 16-tick halves; sub is the position inside the half.
  function automatic logic trit_high(input logic [1:0] code, input logic [7:0] t);
    logic [7:0] sub;
    sub = {4'd0, t[3:0]};
    case (code)
      PT_ZERO:  trit_high = (sub < T_SHORT);
      PT_ONE:   trit_high = (sub < T_LONG);
      PT_FLOAT: trit_high = (t < T_SHORT) || ((t >= (TRIT_TICKS >> 1)) && (sub < T_LONG));
      default:  trit_high = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pt_tx_frame_if.sv
// Word input channel of the frame encoder (valid/ready).
//   s_valid : word offered by the producer
//   s_ready : encoder holding register can take a word
//   s_data  : 2*NUM_TRITS bits of trit codes, MSB pair first
interface pt_tx_frame_if #(
  parameter int NUM_TRITS = 12
);
  logic                   s_valid;
  logic                   s_ready;
  logic [2*NUM_TRITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pt_tx_frame_tick_gen.sv
// pt_tick_gen: strobe generator, one strobe every DIV clk cycles.
//   clk, rst : clock, synchronous active-high reset
//   restart  : zero the divider; the next strobe comes DIV cycles later
//   strobe   : high on the last cycle of each DIV-cycle period
module pt_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic strobe
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  assign strobe = (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || strobe) count_reg <= '0;
    else                          count_reg <= count_reg + CW'(1);
  end
endmodule

// File: rtl/pt_tx_frame.sv
// pt_tx_frame: PT2262-style OOK frame encoder.
// Each accepted word is sent as REPEATS frames of NUM_TRITS trits plus a
// sync bit. A one-word holding register lets the next word queue up.
//   clk, rst   : clock, synchronous active-high reset
//   s          : word input (pt_tx_frame_if.slave)
//   q          : registered serial waveform
//   busy       : frame transmission in progress
//   frame_done : pulse on the last cycle of each frame
//   err_trit   : pulse on the first cycle of each invalid trit
// Build option: define PT_TX_CARRIER_EN to gate q with a carrier square wave
// toggling every CARRIER_DIV cycles (otherwise CARRIER_DIV is unused).
module pt_tx_frame
  import pt_pkg::*;
#(
  parameter int NUM_TRITS   = 12,
  parameter int TICK_DIV    = 1,
  parameter int REPEATS     = 4,
  parameter int CARRIER_DIV = 8
) (
  input  logic           clk,
  input  logic           rst,
  pt_tx_frame_if.slave   s,
  output logic           q,
  output logic           busy,
  output logic           frame_done,
  output logic           err_trit
);
  localparam int WORD_W = 2 * NUM_TRITS;
  localparam int IDX_W  = (NUM_TRITS > 1) ? $clog2(NUM_TRITS) : 1;
  localparam int REP_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TRITS - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEATS - 1);

  if (NUM_TRITS < 1 || NUM_TRITS > 32 || TICK_DIV < 1 || REPEATS < 1 || CARRIER_DIV < 1) begin : g_bad_param
    $error("pt_tx_frame: parameter out of range");
  end

  pt_state_t         state_reg;
  logic [7:0]        tick_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [REP_W-1:0]  rep_reg;
  logic [WORD_W-1:0] shift_reg, word_reg, hold_reg;
  logic              hold_full_reg, tick_first_reg;
  logic              q_reg, busy_reg, frame_done_reg, err_reg;

  logic       tick_stb, sync_end, load_new, reload, frame_start, accept;
  logic       env, carrier;
  logic [1:0] cur_trit;

  assign cur_trit  = shift_reg[WORD_W-1 -: 2];
  assign s.s_ready = ~hold_full_reg & ~rst;
  assign accept    = s.s_valid & s.s_ready;

  assign sync_end    = (state_reg == SYNC) && tick_stb && (tick_reg == SYNC_TICKS - 8'd1);
  assign reload      = sync_end && (rep_reg != REP_LAST);
  // A queued word starts either from IDLE or straight after the last repeat.
  assign load_new    = hold_full_reg && ((state_reg == IDLE) || (sync_end && (rep_reg == REP_LAST)));
  assign frame_start = load_new | reload;

  pt_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (frame_start),
    .strobe  (tick_stb)
  );

  always_comb begin
    env = 1'b0;
    case (state_reg)
      DATA:    env = trit_high(cur_trit, tick_reg);
      SYNC:    env = (tick_reg < T_SHORT);
      default: env = 1'b0;
    endcase
  end

`ifdef PT_TX_CARRIER_EN
  logic carrier_stb, carrier_reg;

  pt_tick_gen #(.DIV(CARRIER_DIV)) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart (frame_start),
    .strobe  (carrier_stb)
  );

  always_ff @(posedge clk) begin
    if (rst)                    carrier_reg <= 1'b0;
    else if (frame_start)       carrier_reg <= 1'b1;
    else if (state_reg == IDLE) carrier_reg <= 1'b0;
    else if (carrier_stb)       carrier_reg <= ~carrier_reg;
  end

  assign carrier = carrier_reg & (state_reg != IDLE);
`else
  assign carrier = 1'b1;
`endif

  // Outputs are registered from the current state, so q, busy, err_trit and
  // frame_done all line up one cycle behind the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tick_reg       <= '0;
      idx_reg        <= '0;
      rep_reg        <= '0;
      hold_full_reg  <= 1'b0;
      tick_first_reg <= 1'b0;
      q_reg          <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      q_reg          <= env & carrier;
      busy_reg       <= (state_reg != IDLE);
      frame_done_reg <= sync_end;
      err_reg        <= (state_reg == DATA) && tick_first_reg && (tick_reg == 8'd0) &&
                        (cur_trit == PT_INVALID);
      // Marks the first clk cycle of each tick so err_trit pulses once.
      tick_first_reg <= frame_start | tick_stb;

      if (accept) begin
        hold_reg      <= s.s_data;
        hold_full_reg <= 1'b1;
      end else if (load_new) begin
        hold_full_reg <= 1'b0;
      end

      if (load_new) begin
        shift_reg <= hold_reg;
        word_reg  <= hold_reg;
        rep_reg   <= '0;
      end else if (reload) begin
        shift_reg <= word_reg;
        rep_reg   <= rep_reg + REP_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (load_new) begin
            state_reg <= DATA;
            tick_reg  <= '0;
            idx_reg   <= '0;
          end
        end
        DATA: begin
          if (tick_stb) begin
            if (tick_reg == TRIT_TICKS - 8'd1) begin
              tick_reg  <= '0;
              shift_reg <= shift_reg << 2;
              if (idx_reg == IDX_LAST) state_reg <= SYNC;
              else                     idx_reg   <= idx_reg + IDX_W'(1);
            end else begin
              tick_reg <= tick_reg + 8'd1;
            end
          end
        end
        SYNC: begin
          if (sync_end) begin
            tick_reg  <= '0;
            idx_reg   <= '0;
            state_reg <= frame_start ? DATA : IDLE;
          end else if (tick_stb) begin
            tick_reg <= tick_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign q          = q_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign err_trit   = err_reg;
endmodule
